cpu_top: RTL and testbench

- Board-level top of a tiny 4-bit TD4-style CPU demo.
- A prescaler divides the board clock into a one-cycle step enable.
- The CPU executes one instruction per step from a fixed 16-word ROM and drives one LED from output-port bit 0.
- Everything lives in the single pin_clock domain; the prescaler produces an enable, not a generated clock.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_top_prescaler.sv | 26 ++
 rtl/cpu_top.sv | 95 +++++++++
 tb/tb_cpu_top.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcodes and the fixed program ROM for the TD4-style demo CPU.
package cpu_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 4;
  localparam int ROM_DEPTH = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic [3:0] op;
    data_t      im;
  } instr_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // Blink program: OUT 1, count A through a full wrap, OUT 0, count again, restart.
  localparam instr_t ROM [ROM_DEPTH] = '{
    8'hB1, 8'h01, 8'hE1, 8'hB0, 8'h01, 8'hE4, 8'hF0, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/cpu_top_prescaler.sv
// Divides the board clock into a one-cycle-wide step enable every RATIO cycles.
module prescaler #(
  parameter int RATIO = 12_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic slow_clock
);

  localparam logic [31:0] LAST = 32'(RATIO - 1);

  logic [31:0] counter;

  assign slow_clock = (counter == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
    end else if (slow_clock) begin
      counter <= '0;
    end else begin
      counter <= counter + 32'd1;
    end
  end

endmodule

// File: rtl/cpu_top.sv
// Board top of a 4-bit TD4-style CPU: one instruction per prescaler step,
// program in a fixed ROM, LED driven from output-port bit 0.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int RATIO = 12_000_000
) (
  input  logic pin_clock,
  input  logic pin_reset,
  output logic pin_led
);

  logic  slow_clock;
  data_t reg_a;
  data_t reg_b;
  addr_t pc;
  data_t out_port;
  logic  carry;

  instr_t          instr;
  data_t           a_next;
  data_t           b_next;
  addr_t           pc_next;
  data_t           out_next;
  logic            carry_next;
  logic [DATA_W:0] sum_a;
  logic [DATA_W:0] sum_b;
  logic            unused_out;

  prescaler #(
    .RATIO(RATIO)
  ) prescaler (
    .clock     (pin_clock),
    .reset     (pin_reset),
    .slow_clock(slow_clock)
  );

  assign instr = ROM[pc];
  assign sum_a = {1'b0, reg_a} + {1'b0, instr.im};
  assign sum_b = {1'b0, reg_b} + {1'b0, instr.im};

  // Carry is rewritten every step; only the two ADDs can leave it set.
  always_comb begin
    a_next     = reg_a;
    b_next     = reg_b;
    out_next   = out_port;
    pc_next    = pc + addr_t'(1);
    carry_next = 1'b0;
    case (instr.op)
      OP_ADD_A: begin
        a_next     = sum_a[DATA_W-1:0];
        carry_next = sum_a[DATA_W];
      end
      OP_MOV_AB: a_next = reg_b;
      OP_IN_A:   a_next = '0;
      OP_MOV_A:  a_next = instr.im;
      OP_MOV_BA: b_next = reg_a;
      OP_ADD_B: begin
        b_next     = sum_b[DATA_W-1:0];
        carry_next = sum_b[DATA_W];
      end
      OP_IN_B:   b_next = '0;
      OP_MOV_B:  b_next = instr.im;
      OP_OUT_B:  out_next = reg_b;
      OP_OUT_IM: out_next = instr.im;
      OP_JNC: begin
        if (!carry) pc_next = instr.im;
      end
      OP_JMP:    pc_next = instr.im;
      default: ;
    endcase
  end

  always_ff @(posedge pin_clock) begin
    if (pin_reset) begin
      reg_a    <= '0;
      reg_b    <= '0;
      pc       <= '0;
      carry    <= 1'b0;
      out_port <= '0;
    end else if (slow_clock) begin
      reg_a    <= a_next;
      reg_b    <= b_next;
      pc       <= pc_next;
      carry    <= carry_next;
      out_port <= out_next;
    end
  end

  assign pin_led = out_port[0];

  // Upper output bits have no pin on this board.
  assign unused_out = ^out_port[DATA_W-1:1];

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top at RATIO=2: table of program milestones,
// reset/prescaler sequences, and randomized resets against an ISA-level model.
module tb_cpu_top;

  logic pin_clock = 1'b0;
  logic pin_reset = 1'b1;
  logic pin_led;

  int checks = 0;
  int errors = 0;

  cpu_top #(
    .RATIO(2)
  ) dut (
    .pin_clock(pin_clock),
    .pin_reset(pin_reset),
    .pin_led  (pin_led)
  );

  always #5 pin_clock = ~pin_clock;

  // Instruction-level reference model.
  int rom [16];
  int m_a, m_b, m_pc, m_carry, m_out;
  int steps;

  typedef struct {
    int step;
    int led;
    int pc;
    int a;
    int carry;
  } vec_t;

  vec_t vecs [12];

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_pc = 0; m_carry = 0; m_out = 0;
    steps = 0;
  endfunction

  function automatic void model_step();
    int op, im, next_pc, c, s;
    op = rom[m_pc] / 16;
    im = rom[m_pc] % 16;
    next_pc = (m_pc + 1) % 16;
    c = 0;
    case (op)
      0:  begin s = m_a + im; m_a = s % 16; c = s / 16; end
      1:  m_a = m_b;
      2:  m_a = 0;
      3:  m_a = im;
      4:  m_b = m_a;
      5:  begin s = m_b + im; m_b = s % 16; c = s / 16; end
      6:  m_b = 0;
      7:  m_b = im;
      9:  m_out = m_b;
      11: m_out = im;
      14: if (m_carry == 0) next_pc = im;
      15: next_pc = im;
      default: ;
    endcase
    m_carry = c;
    m_pc = next_pc;
    steps++;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, steps, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input int cycles);
    @(negedge pin_clock);
    pin_reset = rst;
    repeat (cycles) @(posedge pin_clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, ".led"},   int'(pin_led),      m_out % 2);
    checkOutput({tag, ".out"},   int'(dut.out_port), m_out);
    checkOutput({tag, ".pc"},    int'(dut.pc),       m_pc);
    checkOutput({tag, ".a"},     int'(dut.reg_a),    m_a);
    checkOutput({tag, ".b"},     int'(dut.reg_b),    m_b);
    checkOutput({tag, ".carry"}, int'(dut.carry),    m_carry);
  endtask

  // Wait (bounded) for the step enable, let the step edge pass, advance model.
  task automatic do_step();
    int n = 0;
    @(negedge pin_clock);
    while (!dut.prescaler.slow_clock && n < 8) begin
      @(negedge pin_clock);
      n++;
    end
    if (!dut.prescaler.slow_clock) begin
      checks++;
      errors++;
      $display("[TB] FAIL step_timeout: slow_clock=%0d, expected 1 within 8 cycles", dut.prescaler.slow_clock);
      return;
    end
    @(posedge pin_clock);
    #1;
    model_step();
  endtask

  initial begin
    rom = '{8'hB1, 8'h01, 8'hE1, 8'hB0, 8'h01, 8'hE4, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Milestones after step N of the blink program (hand-derived).
    vecs[0]  = '{1,   1, 1, 0, 0};
    vecs[1]  = '{2,   1, 2, 1, 0};
    vecs[2]  = '{32,  1, 2, 0, 1};
    vecs[3]  = '{33,  1, 3, 0, 0};
    vecs[4]  = '{34,  0, 4, 0, 0};
    vecs[5]  = '{35,  0, 5, 1, 0};
    vecs[6]  = '{65,  0, 5, 0, 1};
    vecs[7]  = '{66,  0, 6, 0, 0};
    vecs[8]  = '{67,  0, 0, 0, 0};
    vecs[9]  = '{68,  1, 1, 0, 0};
    vecs[10] = '{134, 0, 0, 0, 0};
    vecs[11] = '{135, 1, 1, 0, 0};

    // Reset held three cycles.
    model_reset();
    applyStimulus(1, 3);
    checkOutput("reset.counter", int'(dut.prescaler.counter), 0);
    check_model("reset");

    // Prescaler cadence after release: counter 1,0,1,0... with enable at 1.
    applyStimulus(0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge pin_clock);
      checkOutput("presc.counter", int'(dut.prescaler.counter), (i % 2 == 0) ? 1 : 0);
      checkOutput("presc.slow",    int'(dut.prescaler.slow_clock), (i % 2 == 0) ? 1 : 0);
    end

    // Table-driven program milestones, model compared on every step.
    model_reset();
    applyStimulus(1, 2);
    applyStimulus(0, 0);
    for (int v = 0; v < 12; v++) begin
      while (steps < vecs[v].step) begin
        do_step();
        check_model("prog");
      end
      checkOutput("vec.led",   int'(pin_led),   vecs[v].led);
      checkOutput("vec.pc",    int'(dut.pc),    vecs[v].pc);
      checkOutput("vec.a",     int'(dut.reg_a), vecs[v].a);
      checkOutput("vec.carry", int'(dut.carry), vecs[v].carry);
    end

    // Mid-run reset at step 20, one cycle long.
    model_reset();
    applyStimulus(1, 2);
    applyStimulus(0, 0);
    repeat (20) do_step();
    checkOutput("mid.pre_pc", int'(dut.pc), 2);
    applyStimulus(1, 1);
    model_reset();
    checkOutput("mid.counter", int'(dut.prescaler.counter), 0);
    check_model("mid.reset");
    applyStimulus(0, 0);
    do_step();
    checkOutput("mid.led_after", int'(pin_led), 1);
    check_model("mid.step1");

    // Randomized reset pulses at random phases against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) @(negedge pin_clock);
        applyStimulus(1, $urandom_range(1, 3));
        model_reset();
        checkOutput("rnd.counter", int'(dut.prescaler.counter), 0);
        check_model("rnd.reset");
        applyStimulus(0, 0);
      end else begin
        do_step();
        check_model("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
